stream_max_tracker: RTL and testbench
=====================================

Name: stream_max_tracker

Overview:
- Serial counterpart of the team's parallel 4-input max finder.
- Accepts one sample per valid/ready handshake over a fixed-length frame of FRAME_LEN samples.
- Reports the frame maximum and its position (argmax) through a valid/ready output handshake.
- Sits between a sample producer (ADC/packet parser) and a downstream consumer that needs per-frame peak value and position.

Parameters:
- DATA_W, 4, sample width in bits (unsigned).
- FRAME_LEN, 4, samples per frame; legal range 2..256, checked by elaboration assertion.
- IDX_W, $clog2(FRAME_LEN), index width; derived, not overridden.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer presents in_data.
- in_ready  output  1  block can accept a sample.
- in_data  input  DATA_W  unsigned sample.
- out_valid  output  1  frame result available.
- out_ready  input  1  consumer accepts result.
- out_max  output  DATA_W  frame maximum.
- out_idx  output  IDX_W  position (0-based) of maximum within frame.

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk.
- Reset values: state=ACCUM, cnt=0, out_valid=0, out_max=0, out_idx=0. in_ready=0 while rst_n low.
- FSM has two states.
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Sample accept occurs when in_valid&&in_ready.
  - cnt==0: max_r<=in_data, idx_r<=0, unconditionally.
  - else if in_data >= max_r: max_r<=in_data, idx_r<=cnt.
  - Ties therefore resolve to the LATEST index, matching the parallel block's >= rule.
  - Comparison is unsigned at full DATA_W width.
- Each accept increments cnt. On the accept with cnt==FRAME_LEN-1: cnt<=0, state<=DONE.
- Latency: out_valid rises the cycle after the last sample is accepted. out_max/out_idx are registered and include that last sample.
- In DONE:
  - out_max, out_idx and out_valid are held stable until out_valid&&out_ready.
  - Producer stalls while in DONE (in_ready=0); in_data is ignored.
  - On result accept: state<=ACCUM. The next sample may be accepted the following cycle.
  - Throughput: FRAME_LEN+1 cycles per frame minimum.
- in_valid low in ACCUM: no state change. Gaps between samples are allowed anywhere in a frame.
- Reset mid-frame or mid-DONE discards the partial frame and any pending result. No output pulse follows reset.
- in_data X while in_valid=0 must not propagate to state.

Optional Feature:
- Macro: STREAM_MAX_TRACKER_MIN_EN.
- Defined:
  - Adds ports out_min (output, DATA_W) and out_min_idx (output, IDX_W).
  - Tracked in parallel with the maximum. cnt==0 loads unconditionally; otherwise update on in_data <= min_r, so ties also resolve to the latest index.
  - Reset values 0; held in DONE like out_max.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package stream_max_pkg holds:
  - state_e enum {ACCUM, DONE}.
  - Default DATA_W/FRAME_LEN localparams.
  - Function idx_w(int n) returning max(1,$clog2(n)).
- Sub-module: max_cmp_upd (combinational).
  - Inputs: sample, current best, first-flag.
  - Outputs: take-new flag.
  - Parameterised by a compare-direction bit so one instance serves max and another serves min under the macro.

Test Plan:
- Frame 3,9,2,7 (DATA_W=4, FRAME_LEN=4), back-to-back valid, out_ready=1 -> out_valid one cycle after 4th accept, out_max=9, out_idx=1; in_ready low exactly one cycle.
- Ties 5,5,1,5 -> out_max=5, out_idx=3; with MIN_EN, out_min=1, out_min_idx=2.
- All-zero frame 0,0,0,0 -> out_max=0, out_idx=3. Frame F,0,0,0 -> out_max=F, out_idx=0 (first-sample load, no stale carry from previous frame's max).
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1, data 8 presented -> outputs stable, in_ready=0, no sample consumed. Release -> next frame's first sample accepted one cycle after handshake.
- Random in_valid gaps over 100 frames -> out_max/out_idx match scoreboard model for every frame; no lost or duplicated results.
- Assert rst_n low after 2 samples of a frame, then release -> out_valid=0, out_max=0. Next full frame 1,2,3,4 -> out_max=4, out_idx=3, with no carry-over from the aborted frame.

Source files
------------

// File: rtl/stream_max_pkg.sv
// Shared types and defaults for the serial frame max/argmax tracker.
package stream_max_pkg;

    // Two-state frame controller: collecting samples, or holding a result.
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    localparam int DATA_W_DEF    = 4;
    localparam int FRAME_LEN_DEF = 4;

    // Index width for a frame of n samples; never narrower than one bit.
    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stream_max_tracker_max_cmp_upd.sv
// Combinational "take this sample?" decision for a running extreme.
// DIR_MAX=1 tracks a maximum (sample >= best), DIR_MAX=0 a minimum
// (sample <= best). Equality takes the new sample so ties resolve to the
// latest index. The first sample of a frame is always taken.
module max_cmp_upd #(
    parameter int DATA_W  = 4,
    parameter bit DIR_MAX = 1'b1
) (
    input  logic [DATA_W-1:0] i_sample,
    input  logic [DATA_W-1:0] i_best,
    input  logic              i_first,
    output logic              o_take
);

    logic w_better;

    if (DIR_MAX) begin : g_max
        assign w_better = (i_sample >= i_best);
    end else begin : g_min
        assign w_better = (i_sample <= i_best);
    end

    assign o_take = i_first | w_better;

endmodule

// File: rtl/stream_max_tracker.sv
// Serial frame maximum / argmax tracker.
// Consumes FRAME_LEN unsigned samples per frame and reports the frame
// maximum and its 0-based position. Defining STREAM_MAX_TRACKER_MIN_EN adds
// out_min / out_min_idx, tracked alongside the maximum.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. valid must not depend on ready; once out_valid is high,
// out_max/out_idx (and min outputs) stay stable until the transfer.
// While a result is pending in_ready is low, so the producer stalls.
module stream_max_tracker
    import stream_max_pkg::*;
#(
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int FRAME_LEN = FRAME_LEN_DEF,
    localparam int IDX_W     = idx_w(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [IDX_W-1:0]  out_idx,
`ifdef STREAM_MAX_TRACKER_MIN_EN
    output logic [DATA_W-1:0] out_min,
    output logic [IDX_W-1:0]  out_min_idx,
`endif
    output state_e            dbg_state
);

    if (FRAME_LEN < 2 || FRAME_LEN > 256) begin : g_bad_frame_len
        $error("stream_max_tracker: FRAME_LEN must be in 2..256");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_e            r_state;
    logic [IDX_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_max;
    logic [IDX_W-1:0]  r_idx;
    logic              r_out_valid;

    logic w_accept;
    logic w_first;
    logic w_last;
    logic w_take_max;

    // Ready only while collecting; forced low during reset.
    assign in_ready  = rst_n & (r_state == ACCUM);
    assign w_accept  = in_valid & in_ready;
    assign w_first   = (r_cnt == '0);
    assign w_last    = (r_cnt == LAST_IDX);

    assign out_valid = r_out_valid;
    assign out_max   = r_max;
    assign out_idx   = r_idx;
    assign dbg_state = r_state;

    max_cmp_upd #(
        .DATA_W  (DATA_W),
        .DIR_MAX (1'b1)
    ) u_max_cmp (
        .i_sample (in_data),
        .i_best   (r_max),
        .i_first  (w_first),
        .o_take   (w_take_max)
    );

    // Frame controller: counts accepted samples, updates the running max,
    // and holds the result until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_cnt       <= '0;
            r_max       <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (w_take_max) begin
                            r_max <= in_data;
                            r_idx <= r_cnt;
                        end
                        if (w_last) begin
                            r_cnt       <= '0;
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= ACCUM;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ACCUM;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef STREAM_MAX_TRACKER_MIN_EN
    logic [DATA_W-1:0] r_min;
    logic [IDX_W-1:0]  r_min_idx;
    logic              w_take_min;

    assign out_min     = r_min;
    assign out_min_idx = r_min_idx;

    max_cmp_upd #(
        .DATA_W  (DATA_W),
        .DIR_MAX (1'b0)
    ) u_min_cmp (
        .i_sample (in_data),
        .i_best   (r_min),
        .i_first  (w_first),
        .o_take   (w_take_min)
    );

    // Running minimum; only moves on accepted samples, so it is frozen in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min     <= '0;
            r_min_idx <= '0;
        end else if (w_accept && w_take_min) begin
            r_min     <= in_data;
            r_min_idx <= r_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_stream_max_tracker.sv
// Bench for stream_max_tracker: directed frames plus 100 random frames with
// input gaps and random consumer backpressure, all checked against a
// frame-level reference model.
module tb_stream_max_tracker;
  import stream_max_pkg::*;

  localparam int DATA_W    = 4;
  localparam int FRAME_LEN = 4;
  localparam int IDX_W     = idx_w(FRAME_LEN);
`ifdef STREAM_MAX_TRACKER_MIN_EN
  localparam int RES_W = 2 * (DATA_W + IDX_W);
`else
  localparam int RES_W = DATA_W + IDX_W;
`endif

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_max;
  logic [IDX_W-1:0]  out_idx;
`ifdef STREAM_MAX_TRACKER_MIN_EN
  logic [DATA_W-1:0] out_min;
  logic [IDX_W-1:0]  out_min_idx;
`endif
  state_e            dbg_state;

  logic or_fixed;
  logic or_rand;
  logic rand_mode;
  assign out_ready = rand_mode ? or_rand : or_fixed;

  int n_checks;
  int n_errors;
  int n_results;
  int n_frames_exp;

  logic [RES_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] frame_buf[$];

  stream_max_tracker #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_max     (out_max),
    .out_idx     (out_idx),
`ifdef STREAM_MAX_TRACKER_MIN_EN
    .out_min     (out_min),
    .out_min_idx (out_min_idx),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Largest value, then the last position holding it; likewise for the smallest.
  function automatic logic [RES_W-1:0] model(input logic [DATA_W-1:0] s[$]);
    logic [DATA_W-1:0] mx;
    logic [DATA_W-1:0] mn;
    int imx;
    int imn;
    mx = s[0];
    mn = s[0];
    foreach (s[i]) begin
      if (s[i] > mx) mx = s[i];
      if (s[i] < mn) mn = s[i];
    end
    imx = 0;
    imn = 0;
    foreach (s[i]) begin
      if (s[i] == mx) imx = i;
      if (s[i] == mn) imn = i;
    end
`ifdef STREAM_MAX_TRACKER_MIN_EN
    return {mx, IDX_W'(imx), mn, IDX_W'(imn)};
`else
    return {mx, IDX_W'(imx)};
`endif
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [RES_W-1:0] e;
    if (!rst_n) begin
      frame_buf.delete();
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        frame_buf.push_back(in_data);
        if (frame_buf.size() == FRAME_LEN) begin
          exp_q.push_back(model(frame_buf));
          frame_buf.delete();
        end
      end
      if (out_valid && out_ready) begin
        n_results++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_max", 32'(out_max), 32'(e[RES_W-1 -: DATA_W]));
          check("sb_idx", 32'(out_idx), 32'(e[RES_W-DATA_W-1 -: IDX_W]));
`ifdef STREAM_MAX_TRACKER_MIN_EN
          check("sb_min", 32'(out_min), 32'(e[DATA_W+IDX_W-1 -: DATA_W]));
          check("sb_min_idx", 32'(out_min_idx), 32'(e[IDX_W-1:0]));
`endif
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    or_rand = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  // Present one sample and return 1 time unit after the edge that accepts it.
  task automatic send(input logic [DATA_W-1:0] d);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("send_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = 'x;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] a[FRAME_LEN]);
    for (int i = 0; i < FRAME_LEN; i++) send(a[i]);
    in_valid = 1'b0;
    in_data  = 'x;
    n_frames_exp++;
  endtask

  // Back-to-back frame with out_ready=1; checks the result on the next cycle.
  task automatic frame_and_check(input string tag, input logic [DATA_W-1:0] a[FRAME_LEN],
                                 input int e_max, input int e_idx, input int e_min, input int e_min_idx);
    send_frame(a);
    @(negedge clk);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_max"}, 32'(out_max), 32'(e_max));
    check({tag, "_idx"}, 32'(out_idx), 32'(e_idx));
`ifdef STREAM_MAX_TRACKER_MIN_EN
    check({tag, "_min"}, 32'(out_min), 32'(e_min));
    check({tag, "_min_idx"}, 32'(out_min_idx), 32'(e_min_idx));
`else
    if (e_min < 0 || e_min_idx < 0) $display("note: negative min expectation in %s", tag);
`endif
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] fr[FRAME_LEN];
    int wait_cnt;

    n_checks     = 0;
    n_errors     = 0;
    n_results    = 0;
    n_frames_exp = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    or_fixed     = 1'b1;
    or_rand      = 1'b0;
    rand_mode    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_max", 32'(out_max), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_state", 32'(dbg_state), 32'(ACCUM));
    @(posedge clk);
    #1;

    // Basic frame; in_ready must be low for exactly one cycle
    fr = '{4'd3, 4'd9, 4'd2, 4'd7};
    frame_and_check("basic", fr, 9, 1, 2, 2);
    @(negedge clk);
    check("basic_in_ready_back", {31'd0, in_ready}, 32'd1);
    check("basic_out_valid_drop", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Ties resolve to the latest index
    fr = '{4'd5, 4'd5, 4'd1, 4'd5};
    frame_and_check("ties", fr, 5, 3, 1, 2);

    // All zero, then first-sample load with no carry from previous frame
    fr = '{4'd0, 4'd0, 4'd0, 4'd0};
    frame_and_check("zeros", fr, 0, 3, 0, 3);
    fr = '{4'd15, 4'd0, 4'd0, 4'd0};
    frame_and_check("first_max", fr, 15, 0, 0, 3);

    // Backpressure: result held while producer presents 8
    or_fixed = 1'b0;
    fr = '{4'd1, 4'd2, 4'd3, 4'd4};
    send_frame(fr);
    in_valid = 1'b1;
    in_data  = 4'd8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_max", 32'(out_max), 32'd4);
      check("bp_idx", 32'(out_idx), 32'd3);
      check("bp_state", 32'(dbg_state), 32'(DONE));
    end
    @(posedge clk);
    #1;
    or_fixed = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    send(4'd1);
    send(4'd1);
    send(4'd1);
    in_valid = 1'b0;
    n_frames_exp++;
    @(negedge clk);
    check("bp_next_max", 32'(out_max), 32'd8);
    check("bp_next_idx", 32'(out_idx), 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-frame
    send(4'd9);
    send(4'd9);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_max", 32'(out_max), 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fr = '{4'd1, 4'd2, 4'd3, 4'd4};
    frame_and_check("after_rst", fr, 4, 3, 1, 0);

    // Random frames with input gaps and random consumer backpressure
    rand_mode = 1'b1;
    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 1) send(DATA_W'($urandom_range(0, 15)));
        else send(DATA_W'($urandom_range(6, 7)));
      end
      in_valid = 1'b0;
      in_data  = 'x;
      n_frames_exp++;
    end
    rand_mode = 1'b0;
    or_fixed  = 1'b1;

    // Drain and account for every frame
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 50) begin
      @(posedge clk);
      wait_cnt++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("result_count", 32'(n_results), 32'(n_frames_exp));
    check("final_out_valid", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
